// File: rtl/cnu_msg_expand.sv
// cnu_msg_expand
//   Output end of the min-sum check node unit. Takes one compressed record
//   (min1, min2, index of min1, sign product, per-edge signs, degree) and
//   expands it serially into one sign-magnitude check-to-variable message
//   per edge.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready record handshake
//   in_min            {min2, min1}, min1 in the low DATA_W bits
//   in_idx            edge index of min1
//   in_sgn_prod       XOR of all incoming edge signs
//   in_signs          incoming sign per edge (bit e = edge e)
//   in_deg            number of edges (clamped to DEG_MAX, 0 = drop record)
//   out_valid/out_ready message handshake
//   out_msg           {sign, magnitude}
//   out_edge          edge index of out_msg
//   out_last          final edge of the record
//
// Build option
//   OFFSET_CORR_EN    offset min-sum: magnitude becomes max(mag-OFFSET, 0)
module cnu_msg_expand #(
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 8,
  parameter int DEG_MAX = 16,
  parameter int OFFSET  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_min,
  input  logic [IDX_W-1:0]    in_idx,
  input  logic                in_sgn_prod,
  input  logic [DEG_MAX-1:0]  in_signs,
  input  logic [IDX_W-1:0]    in_deg,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W:0]     out_msg,
  output logic [IDX_W-1:0]    out_edge,
  output logic                out_last
);

  localparam int SW = (DEG_MAX > 1) ? $clog2(DEG_MAX) : 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t               state, state_nx;
  logic [DATA_W-1:0]    min1, min2;
  logic [IDX_W-1:0]     idx, deg, e;
  logic                 sgn_prod;
  logic [DEG_MAX-1:0]   signs;

  logic [IDX_W-1:0]     deg_c;
  logic                 last, acc, fire;
  logic [DATA_W-1:0]    mag, mag_o;
  logic                 sgn;

  assign deg_c = (in_deg > IDX_W'(DEG_MAX)) ? IDX_W'(DEG_MAX) : in_deg;

  // in_ready is gated with rst_n so it reads 0 while reset is held, even
  // though the state register already sits in IDLE.
  assign last     = (state == EMIT) && (e == deg - IDX_W'(1));
  assign in_ready = rst_n & ((state == IDLE) | (last & out_ready));
  assign acc      = in_valid & in_ready;
  assign fire     = out_valid & out_ready;

  assign mag = (e == idx) ? min2 : min1;
  assign sgn = sgn_prod ^ signs[e[SW-1:0]];

`ifdef OFFSET_CORR_EN
  assign mag_o = (mag > DATA_W'(OFFSET)) ? mag - DATA_W'(OFFSET) : '0;
`else
  logic unused_offset;
  assign unused_offset = (OFFSET != 0);
  assign mag_o = mag;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and outputs. Outputs are zero outside EMIT and depend only on
  // registered fields, so they hold still while out_ready is low.
  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    out_msg   = '0;
    out_edge  = '0;
    out_last  = 1'b0;
    case (state)
      IDLE: if (acc && deg_c != '0) state_nx = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        out_msg   = {sgn, mag_o};
        out_edge  = e;
        out_last  = last;
        // A record accepted alongside the last beat re-enters EMIT directly.
        if (fire && last) state_nx = (acc && deg_c != '0) ? EMIT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min1     <= '0;
      min2     <= '0;
      idx      <= '0;
      deg      <= '0;
      sgn_prod <= 1'b0;
      signs    <= '0;
      e        <= '0;
    end else if (acc) begin
      min1     <= in_min[DATA_W-1:0];
      min2     <= in_min[2*DATA_W-1:DATA_W];
      idx      <= in_idx;
      deg      <= deg_c;
      sgn_prod <= in_sgn_prod;
      signs    <= in_signs;
      e        <= '0;
    end else if (fire) begin
      e <= e + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_cnu_msg_expand.sv
module tb_cnu_msg_expand;
  localparam int DATA_W = 8, IDX_W = 8, DEG_MAX = 16, OFFSET = 1;

  logic                clk = 0, rst_n = 0;
  logic                in_valid = 0, in_ready;
  logic [2*DATA_W-1:0] in_min = '0;
  logic [IDX_W-1:0]    in_idx = '0;
  logic                in_sgn_prod = 0;
  logic [DEG_MAX-1:0]  in_signs = '0;
  logic [IDX_W-1:0]    in_deg = '0;
  logic                out_valid, out_ready = 1;
  logic [DATA_W:0]     out_msg;
  logic [IDX_W-1:0]    out_edge;
  logic                out_last;

  cnu_msg_expand #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEG_MAX(DEG_MAX), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_min(in_min), .in_idx(in_idx), .in_sgn_prod(in_sgn_prod),
    .in_signs(in_signs), .in_deg(in_deg), .out_valid(out_valid),
    .out_ready(out_ready), .out_msg(out_msg), .out_edge(out_edge),
    .out_last(out_last));

  always #5 clk = ~clk;

  typedef struct {
    int msg;
    int edge_i;
    int last;
  } beat_t;

  beat_t q[$];
  int total = 0, bad = 0;
  int mode = 0, pc = 0, cyc = 0, nbeats = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference expansion: list every message the record must produce.
  task automatic push_rec(input int min1, input int min2, input int idx,
                          input int sp, input int signs, input int deg);
    int d, mag;
    beat_t b;
    d = (deg > DEG_MAX) ? DEG_MAX : deg;
    for (int k = 0; k < d; k++) begin
      mag = (k == idx) ? min2 : min1;
`ifdef OFFSET_CORR_EN
      mag = (mag > OFFSET) ? mag - OFFSET : 0;
`endif
      b.msg    = (((sp ^ ((signs >> k) & 1)) & 1) << DATA_W) + mag;
      b.edge_i = k;
      b.last   = (k == d - 1) ? 1 : 0;
      q.push_back(b);
    end
  endtask

  function automatic logic next_ready();
    pc++;
    case (mode)
      0:       return 1'b1;
      1:       return (pc % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One clock cycle: check outputs at negedge against the model, then advance.
  task automatic step(output bit acc);
    bit exp_rdy;
    exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
    @(negedge clk);
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    chk("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
    if (q.size() != 0) begin
      chk("out_msg", int'(out_msg), q[0].msg);
      chk("out_edge", int'(out_edge), q[0].edge_i);
      chk("out_last", int'(out_last), q[0].last);
      if (out_ready) begin
        void'(q.pop_front());
        nbeats++;
      end
    end
    acc = in_valid && exp_rdy;
    if (acc)
      push_rec(int'(in_min[DATA_W-1:0]), int'(in_min[2*DATA_W-1:DATA_W]),
               int'(in_idx), int'(in_sgn_prod), int'(in_signs), int'(in_deg));
    @(posedge clk);
    #1;
    cyc++;
    out_ready = next_ready();
  endtask

  task automatic offer(input int min1, input int min2, input int idx,
                       input int sp, input int signs, input int deg);
    bit acc;
    int n;
    in_valid = 1;
    in_min = {DATA_W'(min2), DATA_W'(min1)};
    in_idx = IDX_W'(idx);
    in_sgn_prod = 1'(sp);
    in_signs = DEG_MAX'(signs);
    in_deg = IDX_W'(deg);
    acc = 0;
    n = 0;
    while (!acc && n < 60) begin
      step(acc);
      n++;
    end
    chk("accept", int'(acc), 1);
    in_valid = 0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      step(acc);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  initial begin
    int c0;
    // reset state
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_msg", int'(out_msg), 0);
    chk("rst_out_edge", int'(out_edge), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    idle(2);

    // basic expansion
    mode = 0; out_ready = 1;
    offer(3, 9, 2, 1, 4'b0101, 4);
    drain();

    // backpressure 1,0,0,...
    mode = 1; pc = 0; out_ready = 1;
    offer(3, 9, 2, 1, 4'b0101, 4);
    drain();

    // back-to-back deg=2 records: four consecutive valid cycles
    mode = 0; out_ready = 1; nbeats = 0;
    offer(7, 11, 1, 0, 2'b10, 2);
    c0 = cyc;
    offer(4, 6, 0, 1, 2'b01, 2);
    drain();
    chk("b2b_cycles", cyc - c0, 4);
    chk("b2b_beats", nbeats, 4);

    // deg=0: accepted, nothing emitted
    offer(5, 6, 0, 1, 0, 0);
    idle(3);

    // deg=40 clamps to DEG_MAX
    nbeats = 0;
    offer(2, 8, 5, 0, 16'hA5C3, 40);
    drain();
    chk("clamp_beats", nbeats, DEG_MAX);

    // idx beyond degree: min1 everywhere
    offer(6, 1, 20, 1, 4'b1001, 4);
    drain();

    // offset boundary (min1 equals OFFSET)
    offer(1, 5, 1, 1, 4'b0110, 4);
    drain();

    // zero magnitude with sign set
    offer(0, 0, 0, 1, 3'b000, 3);
    drain();

    // randomized records, random backpressure and input gaps
    mode = 2;
    for (int r = 0; r < 40; r++) begin
      offer($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 20),
            $urandom_range(0, 1), $urandom_range(0, 65535), $urandom_range(0, 20));
      idle($urandom_range(0, 2));
    end
    drain();

    // reset mid-record
    mode = 0; out_ready = 1;
    offer(3, 9, 2, 1, 6'b101101, 6);
    idle(2);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_msg", int'(out_msg), 0);
    q.delete();
    #1;
    rst_n = 1;
    idle(5);
    offer(3, 9, 2, 1, 4'b0101, 4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
